// File: rtl/ntt_pass_sequencer_pkg.sv
// Shared definitions for the NTT pass sequencer: polynomial geometry, mode and
// resolver codes, sequencer states and round-count helpers.
package ntt_pass_sequencer_pkg;

    localparam int unsigned DILITHIUM_N    = 256;
    localparam int unsigned NTT_ROUNDS     = 4;
    // Four coefficients per RAM word.
    localparam int unsigned WORDS_PER_POLY = DILITHIUM_N / 4;

    typedef enum logic [2:0] {
        ModeFwdNtt = 3'd0,
        ModeInvNtt = 3'd1,
        ModeMult   = 3'd2,
        ModeAdd    = 3'd3,
        ModeSub    = 3'd4
    } ntt_mode_e;

    typedef enum logic [1:0] {
        ResDecodeTrue = 2'd0,
        ResEncodeTrue = 2'd1,
        ResStandard   = 2'd2
    } mode_resolver_e;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRun,
        StDrain,
        StDone
    } seq_state_e;

    function automatic logic is_ntt_mode(input logic [2:0] m);
        return (m == ModeFwdNtt) || (m == ModeInvNtt);
    endfunction

    // Index of the final round for a command: NTT modes sweep the RAM once per round.
    function automatic logic [1:0] last_round(input logic [2:0] m);
        return is_ntt_mode(m) ? 2'(NTT_ROUNDS - 1) : 2'd0;
    endfunction

endpackage

// File: rtl/ntt_pass_sequencer_wb_delay_line.sv
// Write-back delay line: a DEPTH-stage shift register carrying {valid, addr}.
// All stages clear on synchronous reset so an aborted command leaves no writes behind.
module ntt_pass_sequencer_wb_delay_line #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_pass_sequencer.sv
// Command sequencer for the NTT address unit: issues 64 reads per round, forms delayed
// write-backs and drains between rounds. Optional protocol checker under NTT_SEQ_CHECK_EN.
module ntt_pass_sequencer
    import ntt_pass_sequencer_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 10,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [1:0]        mode_resolver,
    output logic              busy,
    output logic              done,
    output logic              au_rst,
    output logic              au_en,
    output logic [2:0]        au_mode,
    output logic [1:0]        au_mode_resolver,
    input  logic [ADDR_W-1:0] au_ram_addr,
    input  logic              au_round_done,
    input  logic              au_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              err
);

    localparam int unsigned       DL_W       = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(WORDS_PER_POLY - 1);
    localparam logic [4:0]        DRAIN_LAST = 5'(PIPE_LAT - 1);

    seq_state_e        state_q, state_d;
    logic [1:0]        round_q, round_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [4:0]        drain_q, drain_d;
    logic [2:0]        mode_q, mode_d;
    logic [1:0]        res_q, res_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            mode_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        res_d   = res_q;
        unique case (state_q)
            StIdle: begin
                if (start && (mode <= ModeSub)) begin
                    state_d = StInit;
                    mode_d  = mode;
                    res_d   = mode_resolver;
                    round_d = '0;
                    cnt_d   = '0;
                end
            end
            StInit: state_d = StRun;
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    cnt_d   = '0;
                    drain_d = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                // The last write-back of the round lands in this final drain cycle.
                if (drain_q == DRAIN_LAST) begin
                    if (round_q == last_round(mode_q)) begin
                        state_d = StDone;
                    end else begin
                        round_d = round_q + 2'd1;
                        state_d = StRun;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced to their reset values while rst is held.
    assign rd_en            = (state_q == StRun) && !rst;
    assign au_en            = rd_en;
    assign rd_addr          = rd_en ? au_ram_addr : '0;
    assign busy             = (state_q != StIdle) && !rst;
    assign done             = (state_q == StDone) && !rst;
    assign au_rst           = rst || (state_q == StInit);
    assign au_mode          = mode_q;
    assign au_mode_resolver = res_q;

    logic [DL_W-1:0] dl_in, dl_out;

    assign dl_in = {rd_en, rd_addr};

    ntt_pass_sequencer_wb_delay_line #(
        .DEPTH (PIPE_LAT),
        .W     (DL_W)
    ) u_wb_delay_line (
        .clk  (clk),
        .rst  (rst),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign wr_en   = dl_out[DL_W-1] && !rst;
    assign wr_addr = rst ? '0 : dl_out[ADDR_W-1:0];

`ifdef NTT_SEQ_CHECK_EN
    logic err_q;
    logic first_drain;
    logic viol;

    always_comb begin
        first_drain = (state_q == StDrain) && (drain_q == '0);
        viol        = 1'b0;
        if ((state_q != StIdle) && is_ntt_mode(mode_q) && (au_round_done != first_drain)) begin
            viol = 1'b1;
        end
        if (au_done != (first_drain && (round_q == last_round(mode_q)))) begin
            viol = 1'b1;
        end
        if ((state_q == StIdle) && start && (mode > ModeSub)) begin
            viol = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q && !rst;
`else
    logic unused_au_status;
    assign unused_au_status = au_round_done ^ au_done;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_pass_sequencer.sv
// Bench for ntt_pass_sequencer: random addresses and start noise checked against a
// timeline model built from round/drain arithmetic and a read history.
module tb_ntt_pass_sequencer;

    localparam int LAT  = 10;
    localparam int SLOT = 64 + LAT;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst, start, busy, done, au_rst, au_en;
    logic [2:0] mode, au_mode;
    logic [1:0] mode_resolver, au_mode_resolver;
    logic [5:0] au_ram_addr, rd_addr, wr_addr;
    logic       au_round_done, au_done, rd_en, wr_en, err;

    always #5 clk = ~clk;

    ntt_pass_sequencer #(
        .PIPE_LAT (LAT),
        .ADDR_W   (6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .mode_resolver    (mode_resolver),
        .busy             (busy),
        .done             (done),
        .au_rst           (au_rst),
        .au_en            (au_en),
        .au_mode          (au_mode),
        .au_mode_resolver (au_mode_resolver),
        .au_ram_addr      (au_ram_addr),
        .au_round_done    (au_round_done),
        .au_done          (au_done),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .err              (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    bit         m_active = 0;
    int         m_s      = 0;
    logic [2:0] m_mode   = '0;
    logic [1:0] m_res    = '0;
    bit         m_err    = 0;
    int         last_rst = -1;
    bit         rd_v [MAXC];
    logic [5:0] rd_a [MAXC];

    int rd_count, wr_count, done_at, last_wr_at, cmd_start;
    int rd_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rounds_of(input logic [2:0] md);
        return (md <= 3'd1) ? 4 : 1;
    endfunction

    task automatic do_cycle(input bit r, input bit st, input logic [2:0] md, input bit late);
        int k, ph, rnd, pos, t, nr;
        bit ntt, first_dr, e_rd, e_wr, e_err, viol;
        logic [5:0] e_rd_addr, e_wr_addr;
        ph  = 0;
        rnd = 0;
        pos = 0;
        nr  = rounds_of(m_mode);
        ntt = (m_mode <= 3'd1);
        // Phase: 0 idle, 1 init, 2 reading, 3 draining, 4 done.
        if (m_active && !r) begin
            k = cyc - m_s;
            if (k == 1) ph = 1;
            else if (k - 2 < nr * SLOT) begin
                rnd = (k - 2) / SLOT;
                pos = (k - 2) % SLOT;
                ph  = (pos < 64) ? 2 : 3;
            end else ph = 4;
        end
        first_dr = (ph == 3) && (pos == 0);

        rst           = r;
        start         = st;
        mode          = md;
        mode_resolver = 2'($urandom_range(0, 2));
        au_ram_addr   = 6'($urandom);
        au_round_done = ntt && (ph == 3) && (pos == (late ? 1 : 0));
        au_done       = first_dr && (rnd == nr - 1);
        #4;

        e_rd      = (ph == 2);
        e_rd_addr = e_rd ? au_ram_addr : 6'd0;
        rd_v[cyc] = e_rd;
        rd_a[cyc] = e_rd_addr;
        if (r) last_rst = cyc;
        t         = cyc - LAT;
        e_wr      = (t >= 0) && rd_v[t] && (last_rst < t);
        e_wr_addr = e_wr ? rd_a[t] : 6'd0;
`ifdef NTT_SEQ_CHECK_EN
        e_err = r ? 1'b0 : m_err;
`else
        e_err = 1'b0;
`endif
        chk("busy", busy, ph != 0);
        chk("done", done, ph == 4);
        chk("au_rst", au_rst, r || (ph == 1));
        chk("au_en", au_en, e_rd);
        chk("rd_en", rd_en, e_rd);
        chk("rd_addr", rd_addr, e_rd_addr);
        chk("wr_en", wr_en, e_wr);
        chk("wr_addr", wr_addr, e_wr_addr);
        chk("err", err, e_err);
        if (ph != 0) begin
            chk("au_mode", au_mode, m_mode);
            chk("au_mode_resolver", au_mode_resolver, m_res);
        end

        if (rd_en === 1'b1) begin
            rd_count++;
            rd_cyc_q.push_back(cyc);
        end
        if (wr_en === 1'b1) begin
            wr_count++;
            last_wr_at = cyc;
        end
        if (done === 1'b1) done_at = cyc;

        viol = 0;
`ifdef NTT_SEQ_CHECK_EN
        if (!r) begin
            if (ph != 0 && ntt && (au_round_done != first_dr)) viol = 1;
            if (ph == 0 && st && md > 3'd4) viol = 1;
        end
`endif
        m_err = r ? 1'b0 : (m_err | viol);

        if (r) m_active = 0;
        else if (!m_active && st && md <= 3'd4) begin
            m_active = 1;
            m_s      = cyc;
            m_mode   = md;
            m_res    = mode_resolver;
        end else if (ph == 4) m_active = 0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(0, 0, 3'd0, 0);
    endtask

    task automatic run_cmd(input logic [2:0] md, input bit noise, input bit late, input int abort_at);
        int lat_k, n;
        rd_count   = 0;
        wr_count   = 0;
        done_at    = -1;
        last_wr_at = -1;
        rd_cyc_q.delete();
        cmd_start  = cyc;
        do_cycle(0, 1, md, 0);
        lat_k = 2 + rounds_of(md) * SLOT;
        n     = 0;
        while (m_active && n < 400) begin
            if (abort_at > 0 && cyc - m_s == abort_at) do_cycle(1, 0, 3'd0, 0);
            else if (noise && (cyc - m_s) < lat_k && $urandom_range(0, 3) == 0)
                do_cycle(0, 1, 3'($urandom_range(0, 7)), late);
            else do_cycle(0, 0, 3'($urandom_range(0, 7)), late);
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        mode          = '0;
        mode_resolver = '0;
        au_ram_addr   = '0;
        au_round_done = 1'b0;
        au_done       = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) do_cycle(1, 0, 3'd0, 0);
        idle(2);

        // Forward NTT with start noise while busy.
        run_cmd(3'd0, 1, 0, 0);
        chk("fwd_latency", done_at - cmd_start, 298);
        chk("fwd_rd_count", rd_count, 256);
        chk("fwd_wr_count", wr_count, 256);
        idle(2);

        // Elementwise ADD.
        run_cmd(3'd3, 0, 0, 0);
        chk("add_latency", done_at - cmd_start, 76);
        chk("add_rd_count", rd_count, 64);
        chk("add_last_wr", last_wr_at - cmd_start, 75);
        chk("add_rd_span", rd_cyc_q[63] - rd_cyc_q[0], 63);
        idle(2);

        // Inverse NTT round boundary.
        run_cmd(3'd1, 1, 0, 0);
        chk("inv_round_gap", rd_cyc_q[64] - rd_cyc_q[63], 11);
        chk("inv_rd_count", rd_count, 256);
        idle(1);

        // Reset in the middle of round 2, then a clean full run.
        run_cmd(3'd0, 1, 0, 180);
        wr_count = 0;
        done_at  = -1;
        idle(12);
        chk("abort_no_writes", wr_count, 0);
        chk("abort_no_done", done_at, -1);
        run_cmd(3'd0, 0, 0, 0);
        chk("post_abort_latency", done_at - cmd_start, 298);
        idle(2);

        // Illegal mode in idle.
        do_cycle(0, 1, 3'd5, 0);
        idle(3);
`ifdef NTT_SEQ_CHECK_EN
        chk("mode5_err", err, 1);
`endif
        do_cycle(1, 0, 3'd0, 0);
        idle(2);

        // Late round-done from the address unit.
        run_cmd(3'd0, 0, 1, 0);
        idle(3);
`ifdef NTT_SEQ_CHECK_EN
        chk("late_err_sticky", err, 1);
`endif
        do_cycle(1, 0, 3'd0, 0);
        idle(2);

        // Random commands, including illegal modes.
        repeat (4) begin
            run_cmd(3'($urandom_range(0, 7)), 1, 0, 0);
            idle($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
